// File: rtl/writeback_regfile.sv
// SEQ Y86-64 write-back stage: 15x64 register file plus sticky processor status.
// Writes land one edge after a step strobe. There is no backpressure; once stopped, the block ignores step until rst.
module writeback_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_error,
  output logic [63:0] rax,
  output logic [63:0] rcx,
  output logic [63:0] rdx,
  output logic [63:0] rbx,
  output logic [63:0] rsp,
  output logic [63:0] rbp,
  output logic [63:0] rsi,
  output logic [63:0] rdi,
  output logic [63:0] r8,
  output logic [63:0] r9,
  output logic [63:0] r10,
  output logic [63:0] r11,
  output logic [63:0] r12,
  output logic [63:0] r13,
  output logic [63:0] r14,
  output logic [2:0]  stat,
  output logic        halted
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_STOPPED = 1'b1;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;

  localparam int NREG = 15;

  logic [63:0] regs_q [NREG];
  logic [63:0] regs_d [NREG];
  logic [0:0]  state_q, state_d;
  logic [2:0]  stat_q, stat_d;

  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic [2:0]  stat_nxt;
  logic        wr_en;

  always_comb begin
    dst_e = R_NONE;
    dst_m = R_NONE;
    case (icode)
      I_RRMOVQ:                  dst_e = cnd ? rB : R_NONE;
      I_IRMOVQ, I_OPQ:           dst_e = rB;
      I_MRMOVQ:                  dst_m = rA;
      I_CALL, I_RET, I_PUSHQ:    dst_e = R_RSP;
      I_POPQ: begin
        dst_e = R_RSP;
        dst_m = rA;
      end
      default: begin
        dst_e = R_NONE;
        dst_m = R_NONE;
      end
    endcase
  end

  always_comb begin
    stat_nxt = STAT_AOK;
    if (imem_error)        stat_nxt = STAT_ADR;
    else if (!instr_valid) stat_nxt = STAT_INS;
    else if (dmem_error)   stat_nxt = STAT_ADR;
    else if (icode == I_HALT) stat_nxt = STAT_HLT;
  end

  // The instruction that stops the processor must not commit any register.
  assign wr_en = step && (state_q == ST_RUN) && (stat_nxt == STAT_AOK);

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (dst_e == 4'(i))) regs_d[i] = valE;
      // Ordered after valE so a shared destination (popq %rsp) keeps valM.
      if (wr_en && (dst_m == 4'(i))) regs_d[i] = valM;
    end
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    if (step && (state_q == ST_RUN)) begin
      stat_d  = stat_nxt;
      state_d = (stat_nxt == STAT_AOK) ? ST_RUN : ST_STOPPED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      stat_q  <= STAT_AOK;
      for (int i = 0; i < NREG; i++) regs_q[i] <= 64'h0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign rax = regs_q[0];
  assign rcx = regs_q[1];
  assign rdx = regs_q[2];
  assign rbx = regs_q[3];
  assign rsp = regs_q[4];
  assign rbp = regs_q[5];
  assign rsi = regs_q[6];
  assign rdi = regs_q[7];
  assign r8  = regs_q[8];
  assign r9  = regs_q[9];
  assign r10 = regs_q[10];
  assign r11 = regs_q[11];
  assign r12 = regs_q[12];
  assign r13 = regs_q[13];
  assign r14 = regs_q[14];

  assign stat   = stat_q;
  assign halted = (stat_q != STAT_AOK);

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: one task per scenario, inline checks.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic [3:0]  icode, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM;
  logic        instr_valid, imem_error, dmem_error;
  logic [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
  logic [63:0] r8, r9, r10, r11, r12, r13, r14;
  logic [2:0]  stat;
  logic        halted;

  logic [63:0] regs [15];

  int tests_run    = 0;
  int tests_failed = 0;

  writeback_regfile dut (
    .clk(clk), .rst(rst), .step(step), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .instr_valid(instr_valid),
    .imem_error(imem_error), .dmem_error(dmem_error),
    .rax(rax), .rcx(rcx), .rdx(rdx), .rbx(rbx), .rsp(rsp), .rbp(rbp),
    .rsi(rsi), .rdi(rdi), .r8(r8), .r9(r9), .r10(r10), .r11(r11),
    .r12(r12), .r13(r13), .r14(r14), .stat(stat), .halted(halted)
  );

  always #5 clk = ~clk;

  assign regs[0]  = rax;  assign regs[1]  = rcx;  assign regs[2]  = rdx;
  assign regs[3]  = rbx;  assign regs[4]  = rsp;  assign regs[5]  = rbp;
  assign regs[6]  = rsi;  assign regs[7]  = rdi;  assign regs[8]  = r8;
  assign regs[9]  = r9;   assign regs[10] = r10;  assign regs[11] = r11;
  assign regs[12] = r12;  assign regs[13] = r13;  assign regs[14] = r14;

  task automatic idle_inputs();
    step = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    valE = 64'h0; valM = 64'h0;
    instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Completes one instruction; error/valid inputs are left as the caller set them.
  task automatic issue(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m);
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m; step = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      tests_run++;
      if (regs[i] !== 64'h0) begin
        tests_failed++;
        $display("FAIL reset_reg%0d: got %h expected 0", i, regs[i]);
      end
    end
    tests_run++;
    if (stat !== 3'd1 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stat: got stat=%0d halted=%b expected stat=1 halted=0", stat, halted);
    end
  endtask

  task automatic test_irmovq();
    issue(4'h3, 4'hF, 4'h0, 1'b0, 64'h1234, 64'h0);
    tests_run++;
    if (rax !== 64'h1234) begin
      tests_failed++;
      $display("FAIL irmovq_rax: got %h expected 1234", rax);
    end
    for (int i = 1; i < 15; i++) begin
      tests_run++;
      if (regs[i] !== 64'h0) begin
        tests_failed++;
        $display("FAIL irmovq_other%0d: got %h expected 0", i, regs[i]);
      end
    end
    tests_run++;
    if (stat !== 3'd1) begin
      tests_failed++;
      $display("FAIL irmovq_stat: got %0d expected 1", stat);
    end
    // rB = F means no destination at all.
    issue(4'h3, 4'hF, 4'hF, 1'b0, 64'hDEAD, 64'h0);
    tests_run++;
    if (rax !== 64'h1234 || r14 !== 64'h0) begin
      tests_failed++;
      $display("FAIL irmovq_none: got rax=%h r14=%h expected 1234/0", rax, r14);
    end
  endtask

  task automatic test_cmov();
    issue(4'h2, 4'h0, 4'h3, 1'b0, 64'h55, 64'h0);
    tests_run++;
    if (rbx !== 64'h0) begin
      tests_failed++;
      $display("FAIL cmov_cnd0: got rbx=%h expected 0", rbx);
    end
    issue(4'h2, 4'h0, 4'h3, 1'b1, 64'h55, 64'h0);
    tests_run++;
    if (rbx !== 64'h55) begin
      tests_failed++;
      $display("FAIL cmov_cnd1: got rbx=%h expected 55", rbx);
    end
  endtask

  task automatic test_popq();
    issue(4'hB, 4'h0, 4'hF, 1'b0, 64'h108, 64'hAA);
    tests_run++;
    if (rsp !== 64'h108 || rax !== 64'hAA) begin
      tests_failed++;
      $display("FAIL popq_dual: got rsp=%h rax=%h expected 108/aa", rsp, rax);
    end
    issue(4'hB, 4'h4, 4'hF, 1'b0, 64'h110, 64'h77);
    tests_run++;
    if (rsp !== 64'h77) begin
      tests_failed++;
      $display("FAIL popq_rsp: got rsp=%h expected 77", rsp);
    end
    // mrmovq into r14, then call moves rsp to valE.
    issue(4'h5, 4'hE, 4'hF, 1'b0, 64'h0, 64'hBEEF);
    issue(4'h8, 4'hF, 4'hF, 1'b0, 64'hF0, 64'h0);
    tests_run++;
    if (r14 !== 64'hBEEF || rsp !== 64'hF0) begin
      tests_failed++;
      $display("FAIL mrmov_call: got r14=%h rsp=%h expected beef/f0", r14, rsp);
    end
  endtask

  task automatic test_step_gating();
    icode = 4'h6; rB = 4'h5; valE = 64'h9; step = 1'b0;
    tick();
    idle_inputs();
    tests_run++;
    if (rbp !== 64'h0) begin
      tests_failed++;
      $display("FAIL step0_rbp: got %h expected 0", rbp);
    end
    rst = 1'b1;
    issue(4'h6, 4'hF, 4'h5, 1'b0, 64'h9, 64'h0);
    rst = 1'b0;
    tests_run++;
    if (rbp !== 64'h0 || stat !== 3'd1 || rax !== 64'h0) begin
      tests_failed++;
      $display("FAIL rst_collide: got rbp=%h stat=%0d rax=%h expected 0/1/0", rbp, stat, rax);
    end
    issue(4'h6, 4'hF, 4'h5, 1'b0, 64'h9, 64'h0);
    tests_run++;
    if (rbp !== 64'h9) begin
      tests_failed++;
      $display("FAIL opq_rbp: got %h expected 9", rbp);
    end
  endtask

  task automatic test_halt();
    issue(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    tests_run++;
    if (stat !== 3'd2 || halted !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_stat: got stat=%0d halted=%b expected 2/1", stat, halted);
    end
    issue(4'h3, 4'hF, 4'h1, 1'b0, 64'h5, 64'h0);
    tests_run++;
    if (rcx !== 64'h0 || stat !== 3'd2) begin
      tests_failed++;
      $display("FAIL halt_freeze: got rcx=%h stat=%0d expected 0/2", rcx, stat);
    end
    // An error arriving while stopped must not overwrite the sticky status.
    imem_error = 1'b1;
    issue(4'h3, 4'hF, 4'h1, 1'b0, 64'h5, 64'h0);
    tests_run++;
    if (stat !== 3'd2 || rbp !== 64'h9) begin
      tests_failed++;
      $display("FAIL halt_sticky: got stat=%0d rbp=%h expected 2/9", stat, rbp);
    end
  endtask

  task automatic test_error_priority();
    apply_reset();
    imem_error = 1'b1; dmem_error = 1'b1; instr_valid = 1'b0;
    issue(4'h5, 4'h2, 4'hF, 1'b0, 64'h0, 64'h33);
    tests_run++;
    if (stat !== 3'd3 || rdx !== 64'h0 || halted !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_imem: got stat=%0d rdx=%h halted=%b expected 3/0/1", stat, rdx, halted);
    end
    apply_reset();
    tests_run++;
    if (stat !== 3'd1 || halted !== 1'b0 || rdx !== 64'h0 || rax !== 64'h0) begin
      tests_failed++;
      $display("FAIL err_recover: got stat=%0d halted=%b expected 1/0", stat, halted);
    end
    instr_valid = 1'b0; dmem_error = 1'b1;
    issue(4'h5, 4'h2, 4'hF, 1'b0, 64'h0, 64'h33);
    tests_run++;
    if (stat !== 3'd4 || rdx !== 64'h0) begin
      tests_failed++;
      $display("FAIL err_ins: got stat=%0d rdx=%h expected 4/0", stat, rdx);
    end
    apply_reset();
    dmem_error = 1'b1;
    issue(4'h5, 4'h2, 4'hF, 1'b0, 64'h0, 64'h33);
    tests_run++;
    if (stat !== 3'd3 || rdx !== 64'h0) begin
      tests_failed++;
      $display("FAIL err_dmem: got stat=%0d rdx=%h expected 3/0", stat, rdx);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    issue(4'h3, 4'hF, 4'h7, 1'b0, 64'h11, 64'h0);
    issue(4'h6, 4'h7, 4'h7, 1'b0, 64'h22, 64'h0);
    issue(4'hA, 4'h7, 4'hF, 1'b0, 64'h1F8, 64'h0);
    tests_run++;
    if (rdi !== 64'h22 || rsp !== 64'h1F8 || stat !== 3'd1) begin
      tests_failed++;
      $display("FAIL b2b: got rdi=%h rsp=%h stat=%0d expected 22/1f8/1", rdi, rsp, stat);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_irmovq();
    test_cmov();
    test_popq();
    test_step_gating();
    test_halt();
    test_error_priority();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
